// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter
//   Shares the single framebuffer random-access port between NUM_REQ masters (CPU, rasterizer,
//   blitter) on the clk_pix domain. Arbitration is round-robin. A master may lock the grant for up
//   to MAX_LOCK_BEATS consecutive accesses to cover read-modify-write bursts.
//
// Ports
//   clk_pix          pixel clock, the only clock
//   reset_n_i        asynchronous active-low reset
//   req_sel_i        per-master request, held until that master's req_ack_o pulse
//   req_wr_i         per-master write (1) / read (0)
//   req_lock_i       per-master request to keep the grant for the next access
//   req_mask_i       per-master mask, slice [4*i+:4]
//   req_address_i    per-master address, slice [24*i+:24]
//   req_data_in_i    per-master write data, slice [16*i+:16]
//   req_ack_o        one-cycle completion pulse to the granted master
//   req_data_out_o   read data latched at fb_ack_i, valid while req_ack_o pulses
//   fb_sel_o         framebuffer select, dropped combinationally in the ack cycle
//   fb_wr_o          framebuffer write enable
//   fb_mask_o        framebuffer mask
//   fb_address_o     framebuffer address
//   fb_data_in_o     framebuffer write data
//   fb_ack_i         framebuffer completion pulse
//   fb_data_out_i    framebuffer read data, valid with fb_ack_i
//   busy_o           high whenever the FSM is not idle
//   grant_idx_o      index of the current or last granted master
module fb_access_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned MAX_LOCK_BEATS = 4
) (
  input  logic                    clk_pix,
  input  logic                    reset_n_i,
  input  logic [NUM_REQ-1:0]      req_sel_i,
  input  logic [NUM_REQ-1:0]      req_wr_i,
  input  logic [NUM_REQ-1:0]      req_lock_i,
  input  logic [4*NUM_REQ-1:0]    req_mask_i,
  input  logic [24*NUM_REQ-1:0]   req_address_i,
  input  logic [16*NUM_REQ-1:0]   req_data_in_i,
  output logic [NUM_REQ-1:0]      req_ack_o,
  output logic [15:0]             req_data_out_o,
  output logic                    fb_sel_o,
  output logic                    fb_wr_o,
  output logic [3:0]              fb_mask_o,
  output logic [23:0]             fb_address_o,
  output logic [15:0]             fb_data_in_o,
  input  logic                    fb_ack_i,
  input  logic [15:0]             fb_data_out_i,
  output logic                    busy_o,
  output logic [2:0]              grant_idx_o
);

  localparam int unsigned CntW = (MAX_LOCK_BEATS > 1) ? $clog2(MAX_LOCK_BEATS) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StAck} state_e;

  state_e            state_q;
  logic [2:0]        rr_q;
  logic [2:0]        grant_q;
  logic              lock_hold_q;
  logic [CntW-1:0]   lock_cnt_q;
  logic              wr_q;
  logic [3:0]        mask_q;
  logic [23:0]       addr_q;
  logic [15:0]       wdata_q;
  logic [15:0]       rdata_q;

  // Padded to 8 so the 3-bit grant index can address them for any NUM_REQ.
  logic [7:0]        sel_pad;
  logic [7:0]        lock_pad;
  logic [3:0]        cand_sum;
  logic [2:0]        rr_winner;
  logic              rr_found;
  logic              use_lock;
  logic [2:0]        winner;
  logic [2:0]        rr_next;
  logic              win_wr;
  logic [3:0]        win_mask;
  logic [23:0]       win_addr;
  logic [15:0]       win_data;

  assign sel_pad  = 8'(req_sel_i);
  assign lock_pad = 8'(req_lock_i);

  // First requester at or after the round-robin pointer, wrapping modulo NUM_REQ.
  always_comb begin
    rr_winner = rr_q;
    rr_found  = 1'b0;
    cand_sum  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, rr_q} + 4'(i);
      if (cand_sum >= 4'(NUM_REQ)) begin
        cand_sum = cand_sum - 4'(NUM_REQ);
      end
      if (!rr_found && sel_pad[cand_sum[2:0]]) begin
        rr_found  = 1'b1;
        rr_winner = cand_sum[2:0];
      end
    end
  end

  assign use_lock = lock_hold_q && sel_pad[grant_q];
  assign winner   = use_lock ? grant_q : rr_winner;
  assign rr_next  = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;

  // Request fields of the winner, captured on the grant.
  always_comb begin
    win_wr   = 1'b0;
    win_mask = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == 3'(i)) begin
        win_wr   = req_wr_i[i];
        win_mask = req_mask_i[4*i +: 4];
        win_addr = req_address_i[24*i +: 24];
        win_data = req_data_in_i[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      grant_q     <= '0;
      lock_hold_q <= 1'b0;
      lock_cnt_q  <= '0;
      wr_q        <= 1'b0;
      mask_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req_sel_i) begin
            grant_q <= winner;
            wr_q    <= win_wr;
            mask_q  <= win_mask;
            addr_q  <= win_addr;
            wdata_q <= win_data;
            state_q <= StIssue;
            // A lock whose owner stopped requesting is abandoned.
            if (!use_lock) begin
              lock_hold_q <= 1'b0;
              lock_cnt_q  <= '0;
            end
          end
        end
        StIssue: begin
          if (fb_ack_i) begin
            rdata_q <= fb_data_out_i;
            state_q <= StAck;
          end
        end
        StAck: begin
          state_q <= StIdle;
          if (lock_pad[grant_q] && (int'(lock_cnt_q) < int'(MAX_LOCK_BEATS) - 1)) begin
            lock_hold_q <= 1'b1;
            lock_cnt_q  <= lock_cnt_q + 1'b1;
          end else begin
            lock_hold_q <= 1'b0;
            lock_cnt_q  <= '0;
            rr_q        <= rr_next;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    req_ack_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ack_o[i] = (state_q == StAck) && (grant_q == 3'(i));
    end
  end

  // Gated by fb_ack_i so the framebuffer never sees sel high in its own ack cycle.
  assign fb_sel_o       = (state_q == StIssue) && !fb_ack_i;
  assign fb_wr_o        = wr_q;
  assign fb_mask_o      = mask_q;
  assign fb_address_o   = addr_q;
  assign fb_data_in_o   = wdata_q;
  assign req_data_out_o = rdata_q;
  assign busy_o         = (state_q != StIdle);
  assign grant_idx_o    = grant_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Bench for fb_access_arbiter with two masters: a cycle-by-cycle vector table for reads,
// contention, locking and stray acks, then hand sequences for the ack-cycle guard and reset.
module tb_fb_access_arbiter;

  logic        clk_pix = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_sel = '0;
  logic [1:0]  req_wr = '0;
  logic [1:0]  req_lock = '0;
  logic [7:0]  req_mask = 8'hFF;
  logic [47:0] req_addr = {24'h000300, 24'h000100};
  logic [31:0] req_din = {16'h5678, 16'h0000};
  logic [1:0]  req_ack;
  logic [15:0] req_dout;
  logic        fb_sel;
  logic        fb_wr;
  logic [3:0]  fb_mask;
  logic [23:0] fb_addr;
  logic [15:0] fb_din;
  logic        fb_ack = 1'b0;
  logic [15:0] fb_dout = '0;
  logic        busy;
  logic [2:0]  grant;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_pix = ~clk_pix;

  fb_access_arbiter #(
    .NUM_REQ       (2),
    .MAX_LOCK_BEATS(4)
  ) dut (
    .clk_pix       (clk_pix),
    .reset_n_i     (reset_n),
    .req_sel_i     (req_sel),
    .req_wr_i      (req_wr),
    .req_lock_i    (req_lock),
    .req_mask_i    (req_mask),
    .req_address_i (req_addr),
    .req_data_in_i (req_din),
    .req_ack_o     (req_ack),
    .req_data_out_o(req_dout),
    .fb_sel_o      (fb_sel),
    .fb_wr_o       (fb_wr),
    .fb_mask_o     (fb_mask),
    .fb_address_o  (fb_addr),
    .fb_data_in_o  (fb_din),
    .fb_ack_i      (fb_ack),
    .fb_data_out_i (fb_dout),
    .busy_o        (busy),
    .grant_idx_o   (grant)
  );

  // Framebuffer-side view: sel samples and sel rising edges seen at clock edges.
  logic mon_en = 1'b0;
  logic prev_sel = 1'b0;
  int   samples = 0;
  int   starts = 0;
  always @(posedge clk_pix) begin
    if (mon_en) begin
      if (fb_sel) samples <= samples + 1;
      if (fb_sel && !prev_sel) starts <= starts + 1;
      prev_sel <= fb_sel;
    end
  end

  typedef struct packed {
    logic        rst_n;
    logic [1:0]  sel;
    logic [1:0]  lock;
    logic        fack;
    logic [15:0] fdat;
    logic        e_sel;
    logic [1:0]  e_ack;
    logic        e_busy;
    logic [2:0]  e_grant;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst_n, logic [1:0] sel, logic [1:0] lock, logic fack,
                              logic [15:0] fdat, logic e_sel, logic [1:0] e_ack, logic e_busy,
                              logic [2:0] e_grant, logic [15:0] e_rdata);
    vec_t v;
    v.rst_n = rst_n; v.sel = sel; v.lock = lock; v.fack = fack; v.fdat = fdat;
    v.e_sel = e_sel; v.e_ack = e_ack; v.e_busy = e_busy; v.e_grant = e_grant;
    v.e_rdata = e_rdata;
    return v;
  endfunction

  // One access with an immediate fb ack: idle cycle, issue/ack cycle, req_ack cycle.
  task automatic add_acc(input logic [1:0] sel, input logic [1:0] lock, input logic [2:0] pg,
                         input logic [2:0] g, input logic [15:0] prd, input logic [15:0] fdat);
    logic [1:0] oh;
    oh = (g == 3'd0) ? 2'b01 : 2'b10;
    tbl.push_back(mk(1'b1, sel, lock, 1'b0, 16'h0, 1'b0, 2'b00, 1'b0, pg, prd));
    tbl.push_back(mk(1'b1, sel, lock, 1'b1, fdat, 1'b0, 2'b00, 1'b1, g, prd));
    tbl.push_back(mk(1'b1, sel, lock, 1'b0, 16'h0, 1'b0, oh, 1'b1, g, fdat));
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    // Single read of req0, fb acks in the sixth issue cycle.
    tbl.push_back(mk(1'b1, 2'b01, 2'b00, 1'b0, 16'h0, 1'b0, 2'b00, 1'b0, 3'd0, 16'h0));
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk(1'b1, 2'b01, 2'b00, 1'b0, 16'h0, 1'b1, 2'b00, 1'b1, 3'd0, 16'h0));
    end
    tbl.push_back(mk(1'b1, 2'b01, 2'b00, 1'b1, 16'hBEEF, 1'b0, 2'b00, 1'b1, 3'd0, 16'h0));
    tbl.push_back(mk(1'b1, 2'b01, 2'b00, 1'b0, 16'h0, 1'b0, 2'b01, 1'b1, 3'd0, 16'hBEEF));
    tbl.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0, 2'b00, 1'b0, 3'd0, 16'hBEEF));
    // Reset, then contention: grants 0,1,0,1.
    tbl.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0, 2'b00, 1'b0, 3'd0, 16'h0));
    add_acc(2'b11, 2'b00, 3'd0, 3'd0, 16'h0000, 16'hA001);
    add_acc(2'b11, 2'b00, 3'd0, 3'd1, 16'hA001, 16'hA002);
    add_acc(2'b11, 2'b00, 3'd1, 3'd0, 16'hA002, 16'hA003);
    add_acc(2'b11, 2'b00, 3'd0, 3'd1, 16'hA003, 16'hA004);
    // Grant 0 moves the pointer to 1; then req1 locks: 1,1,1,1 then forced rotation to 0.
    add_acc(2'b11, 2'b10, 3'd1, 3'd0, 16'hA004, 16'hB000);
    add_acc(2'b11, 2'b10, 3'd0, 3'd1, 16'hB000, 16'hB001);
    add_acc(2'b11, 2'b10, 3'd1, 3'd1, 16'hB001, 16'hB002);
    add_acc(2'b11, 2'b10, 3'd1, 3'd1, 16'hB002, 16'hB003);
    add_acc(2'b11, 2'b10, 3'd1, 3'd1, 16'hB003, 16'hB004);
    add_acc(2'b11, 2'b10, 3'd1, 3'd0, 16'hB004, 16'hB005);
    add_acc(2'b11, 2'b00, 3'd0, 3'd1, 16'hB005, 16'hB006);
    tbl.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0, 2'b00, 1'b0, 3'd1, 16'hB006));
    // Stray ack while idle.
    tbl.push_back(mk(1'b1, 2'b00, 2'b00, 1'b1, 16'hDEAD, 1'b0, 2'b00, 1'b0, 3'd1, 16'hB006));
    tbl.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0, 2'b00, 1'b0, 3'd1, 16'hB006));

    // Reset state.
    repeat (2) @(negedge clk_pix);
    #1;
    chk("rst.fb_sel", 32'(fb_sel), 32'h0);
    chk("rst.req_ack", 32'(req_ack), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.grant", 32'(grant), 32'h0);
    chk("rst.rdata", 32'(req_dout), 32'h0);
    chk("rst.fb_wr", 32'(fb_wr), 32'h0);
    chk("rst.fb_addr", 32'(fb_addr), 32'h0);

    foreach (tbl[i]) begin
      @(negedge clk_pix);
      reset_n  = tbl[i].rst_n;
      req_sel  = tbl[i].sel;
      req_lock = tbl[i].lock;
      fb_ack   = tbl[i].fack;
      fb_dout  = tbl[i].fdat;
      #1;
      chk($sformatf("vec%0d.fb_sel", i), 32'(fb_sel), 32'(tbl[i].e_sel));
      chk($sformatf("vec%0d.req_ack", i), 32'(req_ack), 32'(tbl[i].e_ack));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d.grant", i), 32'(grant), 32'(tbl[i].e_grant));
      chk($sformatf("vec%0d.rdata", i), 32'(req_dout), 32'(tbl[i].e_rdata));
    end

    // Ack-cycle guard: req0 write held through its ack, inputs disturbed after capture.
    @(negedge clk_pix);
    mon_en = 1'b1;
    fb_ack = 1'b0;
    req_sel = 2'b01;
    req_wr = 2'b01;
    req_addr[23:0] = 24'h000200;
    req_din[15:0] = 16'h1234;
    req_mask[3:0] = 4'h5;
    #1 chk("guard.idle_busy", 32'(busy), 32'h0);
    @(negedge clk_pix);
    req_addr[23:0] = 24'h000999;
    req_din[15:0] = 16'hFFFF;
    req_wr = 2'b00;
    req_mask[3:0] = 4'hA;
    #1;
    chk("guard.fb_sel", 32'(fb_sel), 32'h1);
    chk("guard.fb_addr", 32'(fb_addr), 32'h000200);
    chk("guard.fb_data", 32'(fb_din), 32'h1234);
    chk("guard.fb_wr", 32'(fb_wr), 32'h1);
    chk("guard.fb_mask", 32'(fb_mask), 32'h5);
    @(negedge clk_pix);
    #1 chk("guard.fb_sel2", 32'(fb_sel), 32'h1);
    @(negedge clk_pix);
    fb_ack = 1'b1;
    fb_dout = 16'h0BAD;
    #1 chk("guard.sel_in_ack", 32'(fb_sel), 32'h0);
    @(negedge clk_pix);
    fb_ack = 1'b0;
    #1 chk("guard.req_ack", 32'(req_ack), 32'h1);
    @(negedge clk_pix);
    req_sel = 2'b00;
    #1 chk("guard.busy_after", 32'(busy), 32'h0);
    @(negedge clk_pix);
    mon_en = 1'b0;
    #1;
    chk("guard.sel_edges", 32'(starts), 32'd1);
    chk("guard.sel_samples", 32'(samples), 32'd2);

    // Async reset in the middle of an issue cycle; pointer must come back to 0.
    @(negedge clk_pix);
    req_sel = 2'b10;
    #1 chk("areset.idle", 32'(busy), 32'h0);
    @(negedge clk_pix);
    #1;
    chk("areset.issue_sel", 32'(fb_sel), 32'h1);
    chk("areset.issue_grant", 32'(grant), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("areset.fb_sel", 32'(fb_sel), 32'h0);
    chk("areset.busy", 32'(busy), 32'h0);
    chk("areset.req_ack", 32'(req_ack), 32'h0);
    chk("areset.grant", 32'(grant), 32'h0);
    @(negedge clk_pix);
    fb_ack = 1'b1;
    #1 chk("areset.stray_busy", 32'(busy), 32'h0);
    @(negedge clk_pix);
    reset_n = 1'b1;
    req_sel = 2'b00;
    #1 chk("areset.release_busy", 32'(busy), 32'h0);
    @(negedge clk_pix);
    fb_ack = 1'b0;
    #1;
    chk("areset.stray_ack", 32'(req_ack), 32'h0);
    chk("areset.stray_busy2", 32'(busy), 32'h0);
    req_sel = 2'b11;
    @(negedge clk_pix);
    #1;
    chk("areset.first_grant", 32'(grant), 32'h0);
    chk("areset.first_sel", 32'(fb_sel), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
